// File: rtl/sign_narrow_if.sv
// Handshake bundle for the signed 32-to-16 narrowing unit.
// Producer side is master, the narrowing unit is slave.
interface sign_narrow_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] data_i;
    logic        sat_en_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] data_o;
    logic        ovf_o;
    logic [7:0]  ovf_cnt_o;
    logic        cnt_clr_i;

    modport master (
        output in_valid_i, data_i, sat_en_i, out_ready_i, cnt_clr_i,
        input  in_ready_o, out_valid_o, data_o, ovf_o, ovf_cnt_o
    );

    modport slave (
        input  in_valid_i, data_i, sat_en_i, out_ready_i, cnt_clr_i,
        output in_ready_o, out_valid_o, data_o, ovf_o, ovf_cnt_o
    );
endinterface

// File: rtl/sign_narrow.sv
// Signed 32-to-16 narrowing (truncate or saturate) with a small
// result FIFO and a saturating overflow event counter.
module sign_narrow #(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sign_narrow_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    ovf_cnt;

    logic        full;
    logic        empty;
    logic        accept;
    logic        pop;
    logic        fits;
    logic        ovf;
    logic [15:0] result;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign accept = bus.in_valid_i & ~full;
    assign pop    = bus.out_ready_i & ~empty;

    // Fit test and narrowed value for the word at the input.
    always_comb begin
        fits   = (&bus.data_i[31:15]) | ~(|bus.data_i[31:15]);
        ovf    = ~fits;
        result = bus.data_i[15:0];
        if (ovf && bus.sat_en_i)
            result = bus.data_i[31] ? 16'h8000 : 16'h7FFF;
    end

    // Result storage; contents are qualified by occupancy, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept)
            mem[wr_ptr] <= {result, ovf};
    end

    // Pointers and occupancy; accept and pop together leave count alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)
                count <= count + (AW + 1)'(1);
            else if (pop && !accept)
                count <= count - (AW + 1)'(1);
        end
    end

    // Overflow event counter: clear wins, otherwise count up to 255.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            ovf_cnt <= '0;
        else if (bus.cnt_clr_i)
            ovf_cnt <= '0;
        else if (accept && ovf && ovf_cnt != 8'hFF)
            ovf_cnt <= ovf_cnt + 8'd1;
    end

    // Head outputs are forced to zero while the FIFO is empty.
    always_comb begin
        bus.in_ready_o  = ~full;
        bus.out_valid_o = ~empty;
        bus.ovf_cnt_o   = ovf_cnt;
        bus.data_o      = '0;
        bus.ovf_o       = 1'b0;
        if (!empty) begin
            bus.data_o = mem[rd_ptr][16:1];
            bus.ovf_o  = mem[rd_ptr][0];
        end
    end
endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow with DEPTH = 2.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_sign_narrow;
    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;

    sign_narrow_if bus ();

    sign_narrow #(.DEPTH(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.sat_en_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.cnt_clr_i   = 1'b0;
        repeat (2) step();
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o);
        end
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o);
        end
        checks++;
        if (bus.data_o !== 16'h0 || bus.ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_head: got %h/%b want 0000/0",
                     bus.data_o, bus.ovf_o);
        end
        checks++;
        if (bus.ovf_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", bus.ovf_cnt_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_in_range();
        logic [31:0] vin [4];
        logic [15:0] vexp [4];
        vin[0] = 32'h00007FFF; vexp[0] = 16'h7FFF;
        vin[1] = 32'hFFFF8000; vexp[1] = 16'h8000;
        vin[2] = 32'h00000000; vexp[2] = 16'h0000;
        vin[3] = 32'hFFFFFFFF; vexp[3] = 16'hFFFF;
        bus.sat_en_i    = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid_i = 1'b1;
            bus.data_i     = vin[i];
            checks++;
            if (bus.in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL inrange_ready[%0d]: got %b want 1",
                         i, bus.in_ready_o);
            end
            step();
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.data_o !== vexp[i] ||
                bus.ovf_o !== 1'b0) begin
                errors++;
                $display("FAIL inrange[%0d]: got v=%b %h/%b want v=1 %h/0",
                         i, bus.out_valid_o, bus.data_o, bus.ovf_o, vexp[i]);
            end
        end
        bus.in_valid_i = 1'b0;
        step();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.data_o !== 16'h0) begin
            errors++;
            $display("FAIL inrange_drain: got v=%b %h want v=0 0000",
                     bus.out_valid_o, bus.data_o);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vin [3];
        logic        vsat [3];
        logic [15:0] vexp [3];
        vin[0] = 32'h00012345; vsat[0] = 1'b1; vexp[0] = 16'h7FFF;
        vin[1] = 32'h00012345; vsat[1] = 1'b0; vexp[1] = 16'h2345;
        vin[2] = 32'h80000000; vsat[2] = 1'b1; vexp[2] = 16'h8000;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_i = 1'b1;
            bus.data_i     = vin[i];
            bus.sat_en_i   = vsat[i];
            step();
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.data_o !== vexp[i] ||
                bus.ovf_o !== 1'b1) begin
                errors++;
                $display("FAIL ovf[%0d]: got v=%b %h/%b want v=1 %h/1",
                         i, bus.out_valid_o, bus.data_o, bus.ovf_o, vexp[i]);
            end
        end
        bus.in_valid_i = 1'b0;
        step();
        checks++;
        if (bus.ovf_cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL ovf_cnt: got %0d want 3", bus.ovf_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vin [4];
        logic [15:0] vexp [4];
        logic        vovf [4];
        int          acc;
        vin[0] = 32'h00001111; vexp[0] = 16'h1111; vovf[0] = 1'b0;
        vin[1] = 32'h00032222; vexp[1] = 16'h2222; vovf[1] = 1'b1;
        vin[2] = 32'hFFFF9999; vexp[2] = 16'h9999; vovf[2] = 1'b0;
        vin[3] = 32'hFFF04444; vexp[3] = 16'h4444; vovf[3] = 1'b1;
        acc = 0;
        bus.sat_en_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid_i = 1'b1;
            bus.data_i     = vin[i];
            if (bus.in_ready_o === 1'b1)
                acc++;
            step();
            if (i >= 1) begin
                checks++;
                if (bus.data_o !== vexp[0] || bus.ovf_o !== vovf[0]) begin
                    errors++;
                    $display("FAIL bp_head_stable[%0d]: got %h/%b want %h/%b",
                             i, bus.data_o, bus.ovf_o, vexp[0], vovf[0]);
                end
            end
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepts: got %0d want 2", acc);
        end
        checks++;
        if (bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b want 0", bus.in_ready_o);
        end
        // Full: pop only, w2 offered but refused.
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.data_i      = vin[2];
        step();
        checks++;
        if (bus.data_o !== vexp[1] || bus.ovf_o !== vovf[1]) begin
            errors++;
            $display("FAIL bp_head1: got %h/%b want %h/%b",
                     bus.data_o, bus.ovf_o, vexp[1], vovf[1]);
        end
        // Occupancy 1: accept and pop together, pointers wrap.
        for (int i = 2; i < 4; i++) begin
            bus.data_i = vin[i];
            step();
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b1 ||
                bus.data_o !== vexp[i] || bus.ovf_o !== vovf[i]) begin
                errors++;
                $display("FAIL bp_stream[%0d]: got v=%b r=%b %h/%b want v=1 r=1 %h/%b",
                         i, bus.out_valid_o, bus.in_ready_o, bus.data_o,
                         bus.ovf_o, vexp[i], vovf[i]);
            end
        end
        bus.in_valid_i = 1'b0;
        step();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.ovf_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=5",
                     bus.out_valid_o, bus.ovf_cnt_o);
        end
    endtask

    task automatic test_counter_sat();
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.sat_en_i    = 1'b1;
        bus.data_i      = 32'h40000000;
        repeat (300) step();
        checks++;
        if (bus.ovf_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat: got %0d want 255", bus.ovf_cnt_o);
        end
        checks++;
        if (bus.data_o !== 16'h7FFF || bus.ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL cnt_sat_head: got %h/%b want 7fff/1",
                     bus.data_o, bus.ovf_o);
        end
        bus.cnt_clr_i = 1'b1;
        step();
        checks++;
        if (bus.ovf_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL cnt_clr: got %0d want 0", bus.ovf_cnt_o);
        end
        bus.cnt_clr_i = 1'b0;
        step();
        checks++;
        if (bus.ovf_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL cnt_after_clr: got %0d want 1", bus.ovf_cnt_o);
        end
        bus.in_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.sat_en_i    = 1'b0;
        bus.data_i      = 32'h7FFF0001;
        step();
        bus.data_i = 32'h00005555;
        step();
        bus.in_valid_i = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 ||
            bus.ovf_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL mid_pre: got v=%b r=%b cnt=%0d want v=1 r=0 cnt=2",
                     bus.out_valid_o, bus.in_ready_o, bus.ovf_cnt_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
            bus.ovf_cnt_o !== 8'd0 || bus.data_o !== 16'h0) begin
            errors++;
            $display("FAIL mid_async: got v=%b r=%b cnt=%0d d=%h want v=0 r=1 cnt=0 d=0000",
                     bus.out_valid_o, bus.in_ready_o, bus.ovf_cnt_o,
                     bus.data_o);
        end
        step();
        rst_i = 1'b1;
        bus.out_ready_i = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.data_o !== 16'h0) begin
            errors++;
            $display("FAIL mid_stale: got v=%b d=%h want v=0 d=0000",
                     bus.out_valid_o, bus.data_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_in_range();
        test_overflow();
        test_backpressure();
        test_counter_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/sign_narrow.md
# sign_narrow

Signed 32-to-16 narrowing unit for the single-cycle CPU datapath; the inverse of the 16-to-32 immediate sign extension. It accepts 32-bit signed words over a valid/ready handshake and converts each to a 16-bit halfword, either by truncation or by signed saturation. Results are buffered in a small output FIFO and carry a per-result overflow flag. A saturating overflow event counter is kept for debug and exception logic. The unit sits between the ALU result path and halfword store / packed-data consumers.

## Interface
- DEPTH, 2, number of output FIFO entries; power of two, at least 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input can be accepted; equals "FIFO not full".
- data_i  in  32  signed input word.
- sat_en_i  in  1  1 = saturate, 0 = truncate; sampled with data_i on acceptance.
- out_valid_o  out  1  FIFO head holds a result.
- out_ready_i  in  1  consumer accepts the head.
- data_o  out  16  narrowed result at the FIFO head.
- ovf_o  out  1  head result's input did not fit in signed 16 bits.
- ovf_cnt_o  out  8  count of accepted overflowing inputs; saturates at 255.
- cnt_clr_i  in  1  synchronous clear of ovf_cnt_o.

## Operation
- **Transfers.**
  - Accept occurs when in_valid_i & in_ready_o at a rising edge.
  - Pop occurs when out_valid_o & out_ready_i at a rising edge.
- **Fit test.**
  - fits = (data_i[31:15] all zeros) or (data_i[31:15] all ones).
  - ovf = ~fits, in both modes.
- **Result when fits:** data_i[15:0] in both modes.
- **Result when ~fits, truncate mode:** data_i[15:0]; ovf still 1.
- **Result when ~fits, saturate mode:**
  - data_i[31] = 0 gives 16'h7FFF.
  - data_i[31] = 1 gives 16'h8000.
- **FIFO entry.** {result, ovf}, written at the tail on accept.
- **Pointers and occupancy.**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
- **Simultaneous accept and pop.** Occupancy is unchanged and both pointers advance. This is legal at any non-empty, non-full occupancy.
- **Full.** in_ready_o = 0, so no accept occurs even if a pop happens in the same cycle. There is no pass-through of ready.
- **Empty.** out_valid_o = 0, and data_o and ovf_o are forced to 0.
- **Overflow counter.**
  - Increments by 1 on each accept with ovf = 1.
  - Holds at 255.
  - cnt_clr_i has priority: the counter goes to 0 even if an overflowing accept happens in the same cycle.
- **Reset values.**
  - Occupancy 0 and pointers 0.
  - out_valid_o = 0, data_o = 0, ovf_o = 0, ovf_cnt_o = 0.
  - in_ready_o = 1, since the FIFO is empty.
  - FIFO storage contents need no reset.
- **Reset mid-operation.**
  - All pending results are discarded.
  - out_valid_o drops to 0 asynchronously with reset assertion.

## Timing
- **Latency.** A word accepted at edge N appears on out_valid_o/data_o after edge N (latency 1 cycle) if the FIFO was empty.
- **Throughput.** With out_ready_i held at 1, the unit sustains one word per cycle.
- **Output stability.** data_o and ovf_o are stable while out_valid_o & ~out_ready_i.
- **Combinational paths.** in_ready_o and out_valid_o are decoded from registered occupancy only. There is no combinational path from in_valid_i or out_ready_i to any output.
- **Backpressure.** With out_ready_i = 0, exactly DEPTH words are accepted, then in_ready_o = 0 from the cycle after the DEPTH-th accept.

## Test plan
- **Reset.** Assert rst_i = 0 mid-stream with 2 entries queued. Required: out_valid_o = 0, ovf_cnt_o = 0 and in_ready_o = 1 immediately; no stale result after release.
- **In-range values.** Stream 32'h00007FFF, 32'hFFFF8000, 32'h00000000, 32'hFFFFFFFF with sat_en_i = 1 and out_ready_i = 1. Required: 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, all with ovf_o = 0, at one result per cycle and latency 1.
- **Overflow in both modes.** Send 32'h00012345 with sat_en_i = 1, then with sat_en_i = 0. Required: 16'h7FFF and 16'h2345, both with ovf_o = 1. Then send 32'h80000000 with sat_en_i = 1. Required: 16'h8000 with ovf_o = 1, and ovf_cnt_o = 3.
- **Backpressure.** Hold out_ready_i = 0 and present 4 words. Required: only 2 accepted, in_ready_o = 0, and the head is stable. Release out_ready_i. Required: results come out in order, and simultaneous accept/pop keeps occupancy constant across pointer wrap.
- **Counter saturation and clear.** Accept 300 overflowing words. Required: ovf_cnt_o = 255. Then assert cnt_clr_i together with an overflowing accept. Required: ovf_cnt_o = 0.
